c64_dma_port: RTL and testbench

//  Responder end of the toggle-handshake C64 bus-master port used by the DMA engine (dma_req/dma_ack pair).

---
 rtl/c64_dma_port_pkg.sv | 24 ++
 rtl/c64_dma_port_if.sv | 44 ++++
 rtl/c64_dma_port.sv | 122 ++++++++++++
 tb/tb_c64_dma_port.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/c64_dma_port_pkg.sv
// Shared types for the C64 expansion-port DMA responder.
// State encoding, C64 R/W polarity and counter sizing.
package c64_dma_port_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_BA,
    S_ACCESS,
    S_HOLD
  } state_t;

  localparam logic C64_READ  = 1'b1;
  localparam logic C64_WRITE = 1'b0;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic logic c64_rw(input logic wr);
    return wr ? C64_WRITE : C64_READ;
  endfunction

endpackage

// File: rtl/c64_dma_port_if.sv
// DMA request toggle pair plus C64 expansion-port pins.
// slave = this port, master = DMA engine / board side.
interface c64_dma_port_if;
  import c64_dma_port_pkg::*;

  logic [15:0] dma_a;
  logic [7:0]  dma_d;
  logic        dma_rw;
  logic        dma_req;
  logic        dma_ack;
  logic [7:0]  dma_q;

  logic        phi2_start;
  logic        phi2_sample;
  logic        phi2_end;
  logic        ba;
  logic [7:0]  bus_d_in;

  logic        dma_n;
  logic [15:0] bus_a;
  logic        bus_a_oe;
  logic        bus_rw;
  logic [7:0]  bus_d;
  logic        bus_d_oe;

  modport slave (
    input  dma_a, dma_d, dma_rw, dma_req,
    input  phi2_start, phi2_sample, phi2_end,
    input  ba, bus_d_in,
    output dma_ack, dma_q, dma_n,
    output bus_a, bus_a_oe, bus_rw,
    output bus_d, bus_d_oe
  );

  modport master (
    output dma_a, dma_d, dma_rw, dma_req,
    output phi2_start, phi2_sample, phi2_end,
    output ba, bus_d_in,
    input  dma_ack, dma_q, dma_n,
    input  bus_a, bus_a_oe, bus_rw,
    input  bus_d, bus_d_oe
  );

endinterface

// File: rtl/c64_dma_port.sv
// Toggle-handshake responder: one C64 expansion-port
// cycle per dma_req toggle, /DMA held between bursts.
module c64_dma_port
  import c64_dma_port_pkg::*;
#(
  parameter int HOLD_PHI2 = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  c64_dma_port_if.slave bus
);

  localparam int HW = cnt_w(HOLD_PHI2);

  state_t        state_q;
  logic [15:0]   a_q;
  logic [7:0]    d_q;
  logic          rw_q;
  logic          ack_q;
  logic [7:0]    q_q;
  logic          dma_n_q;
  logic          a_oe_q;
  logic          d_oe_q;
  logic          bus_rw_q;
  logic [15:0]   bus_a_q;
  logic [7:0]    bus_d_q;
  logic [HW-1:0] hold_q;
  logic          pending;
  logic          hold_last;

  assign pending   = bus.dma_req ^ ack_q;
  assign hold_last = (hold_q == HW'(1)) ||
                     (hold_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      d_q      <= '0;
      rw_q     <= 1'b0;
      ack_q    <= 1'b0;
      q_q      <= '0;
      dma_n_q  <= 1'b1;
      a_oe_q   <= 1'b0;
      d_oe_q   <= 1'b0;
      bus_rw_q <= C64_READ;
      bus_a_q  <= '0;
      bus_d_q  <= '0;
      hold_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pending) begin
            a_q     <= bus.dma_a;
            d_q     <= bus.dma_d;
            rw_q    <= bus.dma_rw;
            dma_n_q <= 1'b0;
            state_q <= S_ARM;
          end
        end
        // CPU must see /DMA through a whole phi1
        S_ARM: begin
          if (bus.phi2_end) state_q <= S_WAIT_BA;
        end
        S_WAIT_BA: begin
          if (bus.phi2_start && bus.ba) begin
            a_oe_q   <= 1'b1;
            d_oe_q   <= rw_q;
            bus_rw_q <= c64_rw(rw_q);
            bus_a_q  <= a_q;
            bus_d_q  <= d_q;
            state_q  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (bus.phi2_sample && !rw_q)
            q_q <= bus.bus_d_in;
          if (bus.phi2_end) begin
            a_oe_q   <= 1'b0;
            d_oe_q   <= 1'b0;
            bus_rw_q <= C64_READ;
            ack_q    <= ~ack_q;
            hold_q   <= HW'(HOLD_PHI2);
            if (HOLD_PHI2 == 0) begin
              dma_n_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        // a follow-on request beats hold expiry
        S_HOLD: begin
          if (pending) begin
            a_q     <= bus.dma_a;
            d_q     <= bus.dma_d;
            rw_q    <= bus.dma_rw;
            state_q <= S_WAIT_BA;
          end else if (bus.phi2_end) begin
            if (hold_last) begin
              dma_n_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              hold_q <= hold_q - HW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dma_ack  = ack_q;
  assign bus.dma_q    = q_q;
  assign bus.dma_n    = dma_n_q;
  assign bus.bus_a    = bus_a_q;
  assign bus.bus_a_oe = a_oe_q;
  assign bus.bus_rw   = bus_rw_q;
  assign bus.bus_d    = bus_d_q;
  assign bus.bus_d_oe = d_oe_q;

endmodule

// File: tb/tb_c64_dma_port.sv
// Directed and randomized bench for c64_dma_port.
// phi2 is 8 clks: start@0, sample@3 (or 4), end@4.
module tb_c64_dma_port;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  c64_dma_port_if bif();

  c64_dma_port #(.HOLD_PHI2(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  int phase = 0;
  int cyc = 0;
  bit samp_late = 1'b0;

  always @(posedge clk) begin
    phase <= (phase + 1) % 8;
    cyc   <= cyc + 1;
  end

  assign bif.phi2_start  = (phase == 0);
  assign bif.phi2_sample = (phase == (samp_late ? 4 : 3));
  assign bif.phi2_end    = (phase == 4);

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic       req_t = 1'b0;
  logic       exp_ack = 1'b0;
  logic [7:0] model_q = 8'h00;
  int         ack_cyc = 0;
  bit         saw_n_high = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // bus may only be driven inside the phi2 window
  always @(negedge clk) begin
    if (bif.dma_n) saw_n_high = 1'b1;
    if (reset_n && bif.bus_a_oe) begin
      check("oe_in_phi2",
            32'(phase >= 1 && phase <= 4), 1);
      check("oe_dma_n", bif.dma_n, 0);
    end
    if (reset_n && bif.bus_d_oe)
      check("d_oe_needs_a_oe", bif.bus_a_oe, 1);
  end

  task automatic do_req(input logic [15:0] a,
                        input logic [7:0]  d,
                        input logic        rw,
                        input logic [7:0]  din,
                        input int          stall,
                        input bit          drop);
    int oe_n;
    int st;
    int aph;
    bit seen;
    bit done;
    bit viol;
    logic [15:0] sa;
    logic [7:0]  sd;
    logic        sr;
    logic        sdo;
    oe_n = 0; st = stall; aph = -1;
    seen = 0; done = 0; viol = 0;
    sa = '0; sd = '0; sr = 0; sdo = 0;
    bif.dma_a    = a;
    bif.dma_d    = d;
    bif.dma_rw   = rw;
    bif.bus_d_in = din;
    bif.ba       = (stall == 0);
    req_t        = ~req_t;
    bif.dma_req  = req_t;
    exp_ack      = ~exp_ack;
    if (!rw) model_q = din;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bif.dma_a  = 16'($urandom);
        bif.dma_d  = 8'($urandom);
        bif.dma_rw = ~rw;
      end
      if (bif.bus_a_oe) begin
        oe_n++;
        if (st > 0) viol = 1;
        if (!seen) begin
          sa = bif.bus_a; sd = bif.bus_d;
          sr = bif.bus_rw; sdo = bif.bus_d_oe;
          seen = 1;
        end
        if (drop) bif.ba = 1'b0;
      end
      if (st > 0 && phase == 1) begin
        st--;
        if (st == 0) bif.ba = 1'b1;
      end
      if (bif.dma_ack === exp_ack) begin
        done = 1; aph = phase; ack_cyc = cyc;
      end
    end
    bif.ba = 1'b1;
    if (!done) begin
      check("ack_timeout", 0, 1);
    end else begin
      check("ack_phase", aph, 5);
      check("oe_cycles", oe_n, 4);
      check("bus_a", sa, a);
      check("bus_rw", sr, !rw);
      check("bus_d_oe", sdo, rw);
      if (rw) check("bus_d", sd, d);
      check("dma_q", bif.dma_q, model_q);
      check("oe_while_ba_low", viol, 0);
    end
  endtask

  // /DMA must drop after the 2nd phi2_end past the ack
  task automatic check_release();
    int ends;
    bit done;
    ends = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (phase == 4 && ends == 1)
        check("hold_before", bif.dma_n, 0);
      if (phase == 5) ends++;
      if (ends == 2) begin
        check("hold_release", bif.dma_n, 1);
        done = 1;
      end
    end
    if (!done) check("release_timeout", 0, 1);
  endtask

  int  t_prev;
  bit  oe_seen;
  bit  bad;

  initial begin
    bif.dma_a    = '0;
    bif.dma_d    = '0;
    bif.dma_rw   = 1'b0;
    bif.dma_req  = 1'b0;
    bif.ba       = 1'b1;
    bif.bus_d_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", bif.dma_ack, 0);
    check("rst_q", bif.dma_q, 0);
    check("rst_dma_n", bif.dma_n, 1);
    check("rst_a_oe", bif.bus_a_oe, 0);
    check("rst_d_oe", bif.bus_d_oe, 0);
    check("rst_rw", bif.bus_rw, 1);
    check("rst_bus_a", bif.bus_a, 0);
    check("rst_bus_d", bif.bus_d, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_dma_n", bif.dma_n, 1);

    do_req(16'hD020, 8'h00, 1'b0, 8'h0E, 0, 0);
    check_release();
    repeat (6) @(negedge clk);

    do_req(16'h0400, 8'h41, 1'b1, 8'hA5, 0, 0);
    repeat (30) @(negedge clk);

    do_req(16'hC000, 8'h00, 1'b0, 8'h77, 3, 0);
    repeat (30) @(negedge clk);

    do_req(16'h1000, 8'h01, 1'b1, 8'h00, 0, 0);
    saw_n_high = 1'b0;
    for (int k = 0; k < 3; k++) begin
      t_prev = ack_cyc;
      do_req(16'h1001 + 16'(k), 8'h02 + 8'(k),
             1'(k % 2), 8'h30 + 8'(k), 0, 0);
      check("burst_spacing", ack_cyc - t_prev, 8);
    end
    check("burst_dma_n_low", saw_n_high, 0);
    repeat (30) @(negedge clk);

    samp_late = 1'b1;
    do_req(16'hDC01, 8'h00, 1'b0, 8'h5A, 0, 0);
    samp_late = 1'b0;
    do_req(16'hDC02, 8'h00, 1'b0, 8'h3C, 0, 1);

    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      samp_late = 1'($urandom_range(0, 1));
      do_req(16'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), 8'($urandom),
             ($urandom_range(0, 3) == 0) ?
               int'($urandom_range(1, 3)) : 0,
             ($urandom_range(0, 3) == 0));
    end
    samp_late = 1'b0;
    repeat (30) @(negedge clk);

    bif.dma_a = 16'hBEEF; bif.dma_d = 8'h99;
    bif.dma_rw = 1'b1;
    req_t = ~req_t; bif.dma_req = req_t;
    oe_seen = 1'b0;
    for (int i = 0; i < 60 && !oe_seen; i++) begin
      @(negedge clk);
      if (bif.bus_a_oe) oe_seen = 1'b1;
    end
    check("mid_oe_seen", oe_seen, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_a_oe", bif.bus_a_oe, 0);
    check("mid_rst_d_oe", bif.bus_d_oe, 0);
    check("mid_rst_dma_n", bif.dma_n, 1);
    check("mid_rst_ack", bif.dma_ack, 0);
    req_t = 1'b0; bif.dma_req = 1'b0;
    exp_ack = 1'b0; model_q = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bif.dma_ack !== 1'b0 || bif.dma_n !== 1'b1 ||
          bif.bus_a_oe !== 1'b0)
        bad = 1'b1;
    end
    check("post_rst_quiet", bad, 0);
    check("post_rst_q", bif.dma_q, model_q);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
